// File: rtl/micro_sequencer_pkg.sv
// micro_sequencer_pkg: widths, micro-instruction field map, state encoding and control-store image.
package micro_sequencer_pkg;
   localparam int INST_WIDTH  = 32;
   localparam int MINST_WIDTH = 44;
   localparam int MPC_WIDTH   = 8;
   localparam int MAX_UOPS    = 64;
   localparam int CNT_WIDTH   = $clog2(MAX_UOPS);
   localparam int TYPE_MSB = 43;
   localparam int TYPE_LSB = 41;
   localparam int TGT_MSB  = 17;
   localparam int TGT_LSB  = 10;
   localparam logic [2:0] MT_ALU = 3'b000;
   localparam logic [2:0] MT_CBR = 3'b011;
   localparam logic [2:0] MT_BR  = 3'b100;
   localparam logic [2:0] MT_END = 3'b111;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
   // Each word carries its own address in the low byte so issued streams are easy to trace.
   function automatic logic [MINST_WIDTH-1:0] mk(input logic [2:0] t, input logic [7:0] tgt, input logic [7:0] a);
      return {t, 15'h5a5a ^ {7'd0, a}, a, tgt, 2'b00, a};
   endfunction
   function automatic logic [MINST_WIDTH-1:0] rom_word(input logic [MPC_WIDTH-1:0] a);
      case (a)
         8'h12, 8'h30, 8'h29, 8'h38, 8'h54, 8'h62, 8'h00, 8'hBF: return mk(MT_END, 8'h00, a);
         8'h20: return mk(MT_BR, 8'h30, a);
         8'h28: return mk(MT_CBR, 8'h38, a);
         8'h40: return mk(MT_BR, 8'h40, a);
         8'h61: return mk(MT_CBR, 8'h60, a);
         default: return mk(MT_ALU, 8'h00, a);
      endcase
   endfunction
   function automatic logic [MPC_WIDTH:0] dispatch_entry(input logic [4:0] t);
      case (t)
         5'd1: return {1'b1, 8'h10};
         5'd2: return {1'b1, 8'h20};
         5'd3: return {1'b1, 8'h28};
         5'd4: return {1'b1, 8'h40};
         5'd6: return {1'b1, 8'hFE};
         5'd7: return {1'b1, 8'h50};
         5'd8: return {1'b1, 8'h60};
         5'd9: return {1'b1, 8'h80};
         default: return '0;
      endcase
   endfunction
endpackage

// File: rtl/micro_sequencer_store.sv
// micro_sequencer_store: combinational control store and dispatch table lookup.
module micro_sequencer_store
   import micro_sequencer_pkg::*;
(
   input  logic [MPC_WIDTH-1:0]   upc,
   input  logic [4:0]             op,
   output logic [MINST_WIDTH-1:0] word,
   output logic [MPC_WIDTH:0]     disp
);
   assign word = rom_word(upc);
   assign disp = dispatch_entry(op);
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: dispatches macro instructions to micro-routines and issues one registered micro-word per cycle.
module micro_sequencer
   import micro_sequencer_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   instr_valid,
   input  logic [INST_WIDTH-1:0]  instr_in,
   output logic                   instr_ready,
   output logic [INST_WIDTH-1:0]  instr_q,
   input  logic                   stall,
   input  logic                   cond_flag,
   output logic [MINST_WIDTH-1:0] minstr_out,
   output logic                   minstr_valid,
   output logic                   busy,
   output logic                   illegal_op,
   output logic                   uop_overrun
);
   state_t                 state;
   logic [MPC_WIDTH-1:0]   upc;
   logic [MPC_WIDTH-1:0]   nxt;
   logic [CNT_WIDTH-1:0]   uop_cnt;
   logic [MINST_WIDTH-1:0] w;
   logic [MPC_WIDTH:0]     disp;
   logic [2:0]             wt;
   micro_sequencer_store u_store (.upc(upc), .op(instr_in[31:27]), .word(w), .disp(disp));
   assign wt          = w[TYPE_MSB:TYPE_LSB];
   assign nxt         = (wt == MT_BR || (wt == MT_CBR && cond_flag)) ? w[TGT_MSB:TGT_LSB] : upc + 1'b1;
   assign instr_ready = state == IDLE;
   assign busy        = state == RUN;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         upc          <= '0;
         uop_cnt      <= '0;
         instr_q      <= '0;
         minstr_out   <= '0;
         minstr_valid <= 1'b0;
         illegal_op   <= 1'b0;
         uop_overrun  <= 1'b0;
      end else begin
         illegal_op   <= 1'b0;
         uop_overrun  <= 1'b0;
         minstr_valid <= 1'b0;
         if (state == IDLE) begin
            if (instr_valid) begin
               instr_q <= instr_in;
               if (disp[MPC_WIDTH]) begin
                  upc     <= disp[MPC_WIDTH-1:0];
                  uop_cnt <= '0;
                  state   <= RUN;
               end else illegal_op <= 1'b1;
            end
         end else if (!stall) begin
            // END takes priority over the watchdog
            minstr_out   <= w;
            minstr_valid <= 1'b1;
            uop_cnt      <= uop_cnt + 1'b1;
            if (wt == MT_END) state <= IDLE;
            else if (uop_cnt == CNT_WIDTH'(MAX_UOPS - 1)) begin
               uop_overrun <= 1'b1;
               state       <= IDLE;
            end else upc <= nxt;
         end
      end
   end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed and randomized checks of micro_sequencer against a routine-walking reference model.
module tb_micro_sequencer;
   import micro_sequencer_pkg::*;
   logic        clk = 0, rst = 1, instr_valid = 0, stall = 0, cond_flag = 0;
   logic [31:0] instr_in = '0;
   logic        instr_ready, minstr_valid, busy, illegal_op, uop_overrun;
   logic [31:0] instr_q;
   logic [43:0] minstr_out;
   int errors = 0, checks = 0, ovr_n = 0;
   logic [7:0] log_q[$];
   logic [7:0] ex[$];
   // reference model state
   bit          m_run = 0, e_valid = 0, e_ill = 0, e_ovr = 0;
   int          m_pc = 0, m_cnt = 0;
   logic [43:0] e_word = '0, mw;
   logic [31:0] e_q = '0;
   logic [8:0]  md;
   micro_sequencer dut (.clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_in(instr_in),
      .instr_ready(instr_ready), .instr_q(instr_q), .stall(stall), .cond_flag(cond_flag),
      .minstr_out(minstr_out), .minstr_valid(minstr_valid), .busy(busy),
      .illegal_op(illegal_op), .uop_overrun(uop_overrun));
   always #5 clk = ~clk;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run = 0; m_pc = 0; m_cnt = 0; e_word = '0; e_valid = 0; e_ill = 0; e_ovr = 0; e_q = '0;
      end else begin
         e_ill = 0; e_ovr = 0; e_valid = 0;
         if (!m_run) begin
            if (instr_valid) begin
               e_q = instr_in;
               md = dispatch_entry(instr_in[31:27]);
               if (md[8]) begin m_run = 1; m_pc = md[7:0]; m_cnt = 0; end
               else e_ill = 1;
            end
         end else if (!stall) begin
            mw = rom_word(8'(m_pc));
            e_word = mw; e_valid = 1; m_cnt++;
            if (mw[43:41] == MT_END) m_run = 0;
            else if (m_cnt == MAX_UOPS) begin m_run = 0; e_ovr = 1; end
            else if (mw[43:41] == MT_BR || (mw[43:41] == MT_CBR && cond_flag)) m_pc = mw[17:10];
            else m_pc = (m_pc + 1) % 256;
         end
      end
   end
   task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
      end
   endtask
   task automatic step;
      @(posedge clk);
      @(negedge clk);
      chk("ready", instr_ready, !m_run);
      chk("busy", busy, m_run);
      chk("valid", minstr_valid, e_valid);
      chk("word", minstr_out, e_word);
      chk("illegal", illegal_op, e_ill);
      chk("overrun", uop_overrun, e_ovr);
      chk("instr_q", instr_q, e_q);
      if (minstr_valid) log_q.push_back(minstr_out[7:0]);
      if (uop_overrun) ovr_n++;
   endtask
   task automatic offer(input logic [4:0] t);
      log_q.delete();
      instr_in = {t, 27'($urandom)};
      instr_valid = 1;
      step;
      instr_valid = 0;
   endtask
   task automatic run;
      int n = 0;
      while (busy && n < 300) begin step; n++; end
      chk("timeout", busy, 0);
   endtask
   task automatic seq(input string n);
      chk({n, "_len"}, log_q.size(), ex.size());
      for (int i = 0; i < ex.size() && i < log_q.size(); i++) chk(n, log_q[i], ex[i]);
   endtask
   initial begin
      int o;
      repeat (2) @(negedge clk);
      chk("rst_valid", minstr_valid, 0);
      chk("rst_word", minstr_out, 0);
      chk("rst_ready", instr_ready, 1);
      rst = 0;
      step;
      offer(1); run;
      ex = '{8'h10, 8'h11, 8'h12}; seq("alu_end");
      chk("ready_after_end", instr_ready, 1);
      offer(2); run;
      ex = '{8'h20, 8'h30}; seq("br");
      cond_flag = 1; offer(3); run;
      ex = '{8'h28, 8'h38}; seq("cbr_taken");
      cond_flag = 0; offer(3); run;
      ex = '{8'h28, 8'h29}; seq("cbr_fall");
      offer(7); step; step;
      stall = 1;
      repeat (3) begin
         step;
         chk("stall_valid", minstr_valid, 0);
         chk("stall_hold", minstr_out[7:0], 8'h51);
      end
      stall = 0; run;
      ex = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54}; seq("stall_seq");
      offer(5);
      chk("ill_pulse", illegal_op, 1);
      chk("ill_ready", instr_ready, 1);
      step;
      chk("ill_clear", illegal_op, 0);
      chk("ill_noword", log_q.size(), 0);
      o = ovr_n; offer(4); run;
      ex.delete(); repeat (64) ex.push_back(8'h40); seq("watchdog");
      chk("ovr_once", ovr_n - o, 1);
      o = ovr_n; offer(9); run;
      ex.delete(); for (int i = 8'h80; i <= 8'hBF; i++) ex.push_back(8'(i)); seq("end_vs_wd");
      chk("end_wins", ovr_n - o, 0);
      offer(6); run;
      ex = '{8'hFE, 8'hFF, 8'h00}; seq("wrap");
      offer(7); step; step;
      rst = 1;
      #1;
      chk("arst_valid", minstr_valid, 0);
      chk("arst_word", minstr_out, 0);
      chk("arst_busy", busy, 0);
      chk("arst_q", instr_q, 0);
      chk("arst_ready", instr_ready, 1);
      step;
      rst = 0;
      offer(1); run;
      ex = '{8'h10, 8'h11, 8'h12}; seq("post_rst");
      repeat (3000) begin
         instr_valid = 1'($urandom_range(0, 1));
         instr_in    = {5'($urandom_range(0, 15)), 27'($urandom)};
         stall       = $urandom_range(0, 3) == 0;
         cond_flag   = 1'($urandom_range(0, 1));
         step;
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
